// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives it to instruction memory and
// registers the returned word into an IF/ID slot with a valid/ready handshake.
module fetch_unit #(
  parameter int                  REG_SIZE = 32,
  parameter logic [REG_SIZE-1:0] RESET_PC = '0,
  parameter logic [REG_SIZE-1:0] NOP_INST = REG_SIZE'(32'h0000_0013)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [REG_SIZE-1:0] imem_addr_o,
  input  logic [REG_SIZE-1:0] imem_inst_i,
  input  logic                redirect_i,
  input  logic [REG_SIZE-1:0] redirect_pc_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [REG_SIZE-1:0] inst_o,
  output logic [REG_SIZE-1:0] pc_o,
  output logic [REG_SIZE-1:0] pc_plus4_o,
  output logic                misaligned_o,
  output logic [REG_SIZE-1:0] fetch_count_o
);

  typedef enum logic {FETCH, TRAP} state_t;

  localparam logic [REG_SIZE-1:0] FOUR = REG_SIZE'(4);
  localparam logic [REG_SIZE-1:0] ONE  = REG_SIZE'(1);

  state_t              state_reg;
  logic [REG_SIZE-1:0] pc_reg;
  logic                valid_reg;
  logic [REG_SIZE-1:0] inst_reg;
  logic [REG_SIZE-1:0] pc_out_reg;
  logic [REG_SIZE-1:0] pc_plus4_reg;
  logic                misaligned_reg;
  logic [REG_SIZE-1:0] fetch_count_reg;

  logic load;
  logic handshake;
  logic redirect_misaligned;

  assign load                = !valid_reg || ready_i;
  assign handshake           = valid_reg && ready_i;
  assign redirect_misaligned = redirect_pc_i[1:0] != 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC;
      valid_reg       <= 1'b0;
      inst_reg        <= NOP_INST;
      pc_out_reg      <= '0;
      pc_plus4_reg    <= FOUR;
      misaligned_reg  <= 1'b0;
      fetch_count_reg <= '0;
    end else begin
      // Handshakes are counted even on the edge that flushes the slot.
      if (handshake) begin
        fetch_count_reg <= fetch_count_reg + ONE;
      end
      case (state_reg)
        FETCH: begin
          if (redirect_i && redirect_misaligned) begin
            state_reg      <= TRAP;
            misaligned_reg <= 1'b1;
            valid_reg      <= 1'b0;
            inst_reg       <= NOP_INST;
          end else if (redirect_i) begin
            pc_reg    <= redirect_pc_i;
            valid_reg <= 1'b0;
            inst_reg  <= NOP_INST;
          end else if (load) begin
            inst_reg     <= imem_inst_i;
            pc_out_reg   <= pc_reg;
            pc_plus4_reg <= pc_reg + FOUR;
            valid_reg    <= 1'b1;
            pc_reg       <= pc_reg + FOUR;
          end
        end
        TRAP: begin
          valid_reg      <= 1'b0;
          inst_reg       <= NOP_INST;
          misaligned_reg <= 1'b1;
        end
        default: state_reg <= TRAP;
      endcase
    end
  end

  assign imem_addr_o   = pc_reg;
  assign valid_o       = valid_reg;
  assign inst_o        = inst_reg;
  assign pc_o          = pc_out_reg;
  assign pc_plus4_o    = pc_plus4_reg;
  assign misaligned_o  = misaligned_reg;
  assign fetch_count_o = fetch_count_reg;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory. Holds the program counter and drives it as the memory address.
- Captures the combinationally returned instruction into an IF/ID output register, with a valid/ready handshake towards decode.
- Accepts branch/jump redirects from execute. Traps on misaligned redirect targets.

Parameters:
- REG_SIZE, 32, datapath width of PC and instruction.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, value driven on inst_o while not valid (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr_o  output  REG_SIZE  fetch address to instruction memory; equals internal PC.
- imem_inst_i  input  REG_SIZE  instruction returned combinationally for imem_addr_o in the same cycle.
- redirect_i  input  1  execute requests a PC change this cycle.
- redirect_pc_i  input  REG_SIZE  target PC for redirect.
- ready_i  input  1  decode can accept inst_o this cycle.
- valid_o  output  1  inst_o/pc_o hold a valid fetched instruction.
- inst_o  output  REG_SIZE  fetched instruction (IF/ID register).
- pc_o  output  REG_SIZE  PC of inst_o.
- pc_plus4_o  output  REG_SIZE  pc_o + 4, for link-register writes.
- misaligned_o  output  1  sticky trap flag: redirect target not word-aligned.
- fetch_count_o  output  REG_SIZE  number of instructions handed to decode (valid_o && ready_i).

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, valid_o=0, inst_o=NOP_INST, pc_o=0, pc_plus4_o=4, misaligned_o=0, fetch_count_o=0, state=FETCH.
- imem_addr_o = pc at all times, combinational from the PC register.
- States:
  - FETCH: normal operation.
  - TRAP: entered on a misaligned redirect; exited only by rst.
- Definition: load = !valid_o || ready_i (output register empty or being consumed).
- FETCH priority per rising edge, highest first:
  1. redirect_i && redirect_pc_i[1:0]!=0: state<=TRAP, misaligned_o<=1, valid_o<=0, inst_o<=NOP_INST, pc unchanged.
  2. redirect_i aligned: pc<=redirect_pc_i, valid_o<=0, inst_o<=NOP_INST (flush of the wrong-path instruction, even if ready_i=1 and it was accepted; fetch_count_o still increments if valid_o && ready_i). The target instruction appears on valid_o exactly 1 cycle later.
  3. load: inst_o<=imem_inst_i, pc_o<=pc, pc_plus4_o<=pc+4, valid_o<=1, pc<=pc+4.
  4. Otherwise (valid_o && !ready_i): stall. pc, inst_o, pc_o, valid_o are all held stable.
- fetch_count_o increments by 1 on every edge with valid_o && ready_i, in all states. It wraps modulo 2^REG_SIZE.
- TRAP: valid_o=0, inst_o=NOP_INST, pc frozen, redirect_i ignored, misaligned_o=1.
- Latency: 1 cycle from the PC register to valid_o. Throughput is 1 instruction/cycle while ready_i=1.
- Arithmetic: PC increments modulo 2^REG_SIZE (32'hFFFF_FFFC + 4 = 0). No out-of-range check (memory indexes pc[REG_SIZE-1:2]).
- Redirect during a stall takes priority over the stall: the held instruction is discarded.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronous). The first valid_o after release is at the 1st rising edge following deassertion.

Test Plan:
- Reset release, memory words 0,1,2 = 32'h00500093, 32'h00A00113, 32'h002081B3, ready_i=1 -> cycles 1..3 after release: valid_o=1 with inst_o = those words, pc_o=0,4,8, pc_plus4_o=4,8,12; fetch_count_o=3 after the third handshake.
- Stall: ready_i=0 for 3 cycles while valid_o=1 with pc_o=8 -> inst_o, pc_o, imem_addr_o=12 all stable; on ready_i=1, next pc_o=12, no instruction skipped or duplicated.
- Aligned redirect to 32'h40 while pc_o=4, ready_i=1 -> next cycle valid_o=0, inst_o=NOP_INST; following cycle pc_o=32'h40, valid_o=1; also repeat during a stall, with the same result.
- Misaligned redirect to 32'h42 -> misaligned_o=1, valid_o=0 from the next cycle; a later aligned redirect to 32'h80 is ignored; pc stays frozen until rst.
- Wrap-around: redirect to 32'hFFFF_FFFC -> pc_o=32'hFFFF_FFFC, pc_plus4_o=0, next pc_o=0.
- Reset mid-run (assert between edges while valid_o=1, pc=32'h20) -> outputs take reset values without a clock edge; after release, fetch restarts at RESET_PC and fetch_count_o restarts from 0.
